debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//   Multi-channel debouncer for front-panel buttons and switches feeding the synth control logic.
//   Each channel has:
//   - a 2-flop synchroniser;
//   - a stability counter that produces a clean level;
//   - single-cycle rise/fall pulses;
//   - a per-channel press FSM that emits a long-press pulse and optional auto-repeat pulses.
//   It replaces per-button single-channel debouncers with one parametrised instance.
// PARAMETERS
//   CHANNELS      5           number of independent input channels (>=1)
//   DB_CYCLES     1_000_000   consecutive differing cycles required to accept a new level (10 ms @ 100 MHz)
//   HOLD_CYCLES   50_000_000  cycles from press pulse to hold pulse (500 ms)
//   REPEAT_CYCLES 10_000_000  cycles between repeat pulses after hold (100 ms)
//   REPEAT_EN     1           1: generate repeat pulses; 0: hold pulse only
//   PRESS_LEVEL   1           debounced level meaning "pressed" (0 for active-low buttons)
//   Counter widths: $clog2 of the largest cycle count they must reach, +1.
// PORTS
//   clk     in   1         system clock
//   rst_n   in   1         asynchronous active-low reset
//   src     in   CHANNELS  raw asynchronous button/switch inputs
//   level   out  CHANNELS  debounced level per channel
//   rise    out  CHANNELS  1-cycle pulse: level went 0->1
//   fall    out  CHANNELS  1-cycle pulse: level went 1->0
//   hold    out  CHANNELS  1-cycle pulse: channel pressed for HOLD_CYCLES
//   rpt     out  CHANNELS  1-cycle auto-repeat pulse while held
// BEHAVIOUR
//   Reset (rst_n low, asynchronous, any time)
//   - sync flops and level reset to ~PRESS_LEVEL (released); all counters reset to 0.
//   - rise/fall/hold/rpt reset to 0; FSMs reset to IDLE.
//   - No pulses are generated by the reset release itself.
//   Channels are fully independent; per channel i:
//   Sync: s0<=src[i]; s1<=s0. Only s1 is used downstream.
//   Debounce counter dc:
//   - if s1==level: dc<=0.
//   - else if dc==DB_CYCLES-1: level<=s1; dc<=0; pulse rise or fall.
//   - else dc<=dc+1.
//   - Any bounce back to the current level clears dc.
//   Latency: a clean src change is reflected on level, with the rise/fall pulse in the same cycle,
//   at the (DB_CYCLES+2)th rising edge counting the first edge that samples the new value.
//   - A glitch of <DB_CYCLES+... cycles at s1 never changes level.
//   - rise/fall are high for exactly one cycle and never both in the same cycle.
//   Press FSM (pressed == level==PRESS_LEVEL; press edge == the rise or fall pulse that enters pressed):
//   - IDLE: on press edge -> WAIT_HOLD, hc<=0.
//   - WAIT_HOLD: hc++ each cycle. hold pulses exactly HOLD_CYCLES cycles after the press-edge cycle.
//     Then: if REPEAT_EN -> REPEAT with hc<=0; else -> LATCHED.
//   - REPEAT: rpt pulses every REPEAT_CYCLES cycles after the hold cycle while pressed.
//   - LATCHED: no further pulses.
//   - Leaving pressed (release edge) in any state -> IDLE in the same edge.
//     No hold/rpt is asserted in or after the release cycle.
//   - Release on the exact cycle hold/rpt would fire: release wins, no pulse.
//   - Re-press restarts from WAIT_HOLD with hc=0.
//   Counters saturate-free by construction: hc never exceeds max(HOLD,REPEAT)-1. No wrap is possible.
// TESTING (bench params: CHANNELS=2, DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, PRESS_LEVEL=1)
//   1 Reset
//     - Stimulus: rst_n=0, src=2'b11, then release rst_n.
//     - Response: level=0 and no pulses during reset. level[i]=1 with rise pulses 6 edges after release.
//   2 Clean press
//     - Stimulus: src[0] 0->1 and held.
//     - Response: level[0]=1 and rise[0]=1 on 6th edge, for 1 cycle. Channel 1 outputs unchanged.
//   3 Bounce
//     - Stimulus: src[0] pattern 1,1,1,0,0 repeated 4x, then stays 1.
//     - Response: no level/rise during bounce. rise 6 edges after the final 0->1.
//   4 Hold/repeat
//     - Stimulus: press held 60 cycles after rise, then release.
//     - Response: hold at rise+20; rpt at +28,+36,+44,+52,+60 until release.
//       fall 6 edges after release; no rpt after release.
//   5 Simultaneous
//     - Stimulus: both channels press in the same cycle; ch1 releases at rise+19.
//     - Response: ch0 hold at +20. ch1 has no hold; its fall follows its own debounce.
//   6 REPEAT_EN=0, PRESS_LEVEL=0
//     - Stimulus: src held low 60 cycles.
//     - Response: fall at edge 6, one hold at fall+20, zero rpt; mid-hold rst_n pulse returns all outputs to reset values.

Source files
------------

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//   Multi-channel debouncer for front-panel buttons and switches. Every channel
//   is independent and has:
//     - a 2-flop synchroniser on the raw input,
//     - a stability counter that accepts a new level only after DB_CYCLES
//       consecutive cycles of disagreement,
//     - single-cycle rise/fall pulses aligned with the level change,
//     - a press FSM that emits one hold pulse HOLD_CYCLES after the press edge
//       and then, if REPEAT_EN, a repeat pulse every REPEAT_CYCLES.
//
// Ports
//   clk    in   1         system clock
//   rst_n  in   1         asynchronous active-low reset
//   src    in   CHANNELS  raw asynchronous inputs
//   level  out  CHANNELS  debounced level
//   rise   out  CHANNELS  1-cycle pulse, level 0->1
//   fall   out  CHANNELS  1-cycle pulse, level 1->0
//   hold   out  CHANNELS  1-cycle pulse, pressed for HOLD_CYCLES
//   rpt    out  CHANNELS  1-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module debounce_bank #(
  parameter int CHANNELS      = 5,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter bit PRESS_LEVEL   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] src,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] rpt
);

  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DC_W   = $clog2(DB_CYCLES) + 1;
  localparam int HC_W   = $clog2(HC_MAX) + 1;

  localparam logic [DC_W-1:0] DB_LAST   = DC_W'(DB_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] RPT_LAST  = HC_W'(REPEAT_CYCLES - 1);

  // Released level: what the sync flops and level hold out of reset, so that
  // reset release never looks like an edge.
  localparam logic IDLE_LEVEL = ~PRESS_LEVEL;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HOLD,
    REPEAT,
    LATCHED
  } state_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic            s0_q, s1_q;
    logic            level_q, level_d;
    logic            rise_q, rise_d, fall_q, fall_d;
    logic            hold_q, hold_d, rpt_q, rpt_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic [HC_W-1:0] hc_q, hc_d;
    state_e          state_q, state_d;
    logic            accept;
    logic            press_edge, release_edge;

    // Debounce: count consecutive cycles where the synchronised input
    // disagrees with the accepted level; any agreement restarts the count.
    always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      dc_d    = dc_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      accept  = 1'b0;
      if (s1_q == level_q) begin
        dc_d = '0;
      end else if (dc_q == DB_LAST) begin
        accept  = 1'b1;
        level_d = s1_q;
        dc_d    = '0;
        rise_d  = s1_q;
        fall_d  = ~s1_q;
      end else begin
        dc_d = dc_q + DC_W'(1);
      end
    end

    // Edges are taken from the acceptance event itself, so the FSM moves on
    // the same clock edge that updates level.
    assign press_edge   = accept && (s1_q == PRESS_LEVEL);
    assign release_edge = accept && (s1_q != PRESS_LEVEL);

    // Press FSM. A release edge overrides everything, including a hold/rpt
    // that would otherwise fire on that same edge.
    always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      hold_d  = 1'b0;
      rpt_d   = 1'b0;
      if (release_edge) begin
        state_d = IDLE;
        hc_d    = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (press_edge) begin
              state_d = WAIT_HOLD;
              hc_d    = '0;
            end
          end
          WAIT_HOLD: begin
            if (hc_q == HOLD_LAST) begin
              hold_d  = 1'b1;
              hc_d    = '0;
              state_d = REPEAT_EN ? REPEAT : LATCHED;
            end else begin
              hc_d = hc_q + HC_W'(1);
            end
          end
          REPEAT: begin
            if (hc_q == RPT_LAST) begin
              rpt_d = 1'b1;
              hc_d  = '0;
            end else begin
              hc_d = hc_q + HC_W'(1);
            end
          end
          LATCHED: ;
          default: begin
            state_d = IDLE;
            hc_d    = '0;
          end
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0_q    <= IDLE_LEVEL;
        s1_q    <= IDLE_LEVEL;
        level_q <= IDLE_LEVEL;
        dc_q    <= '0;
        hc_q    <= '0;
        state_q <= IDLE;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        hold_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        s0_q    <= src[i];
        s1_q    <= s0_q;
        level_q <= level_d;
        dc_q    <= dc_d;
        hc_q    <= hc_d;
        state_q <= state_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        hold_q  <= hold_d;
        rpt_q   <= rpt_d;
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign hold[i]  = hold_q;
    assign rpt[i]   = rpt_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
//   Directed bench for debounce_bank. dut_a: active-high presses with repeat;
//   dut_b: active-low presses, hold only. Cycle k means "after the k-th rising
//   edge" counted from the event named in each step.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  logic [1:0] src_a, src_b;
  logic [1:0] level_a, rise_a, fall_a, hold_a, rpt_a;
  logic [1:0] level_b, rise_b, fall_b, hold_b, rpt_b;
  logic [1:0] seen;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS(2), .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(1'b1), .PRESS_LEVEL(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .src(src_a), .level(level_a),
    .rise(rise_a), .fall(fall_a), .hold(hold_a), .rpt(rpt_a)
  );

  debounce_bank #(
    .CHANNELS(2), .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(1'b0), .PRESS_LEVEL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .src(src_b), .level(level_b),
    .rise(rise_b), .fall(fall_b), .hold(hold_b), .rpt(rpt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- 1: reset ----------------
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    src_a   = 2'b11;
    src_b   = 2'b11;
    repeat (3) tick();
    check("rst level_a", level_a, 2'b00);
    check("rst rise_a", rise_a, 2'b00);
    check("rst hold_a|rpt_a", hold_a | rpt_a, 2'b00);
    check("rst level_b", level_b, 2'b11);
    check("rst fall_b", fall_b, 2'b00);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t1 level_a c%0d", k), level_a, (k == 6) ? 2'b11 : 2'b00);
      check($sformatf("t1 rise_a c%0d", k), rise_a, (k == 6) ? 2'b11 : 2'b00);
      check($sformatf("t1 fall_b c%0d", k), fall_b, 2'b00);
    end
    check("t1 level_b", level_b, 2'b11);
    // release both before any hold can fire (fall at cycle 6 after rise)
    src_a = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t1 fall_a c%0d", k), fall_a, (k == 6) ? 2'b11 : 2'b00);
      check($sformatf("t1 rise_a off c%0d", k), rise_a, 2'b00);
    end
    seen = '0;
    repeat (25) begin
      tick();
      seen = seen | hold_a | rpt_a;
    end
    check("t1 no hold after early release", seen, 2'b00);

    // ---------------- 2: clean press ----------------
    src_a[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t2 level_a c%0d", k), level_a, (k == 6) ? 2'b01 : 2'b00);
      check($sformatf("t2 rise_a c%0d", k), rise_a, (k == 6) ? 2'b01 : 2'b00);
    end
    tick();
    check("t2 rise_a one cycle", rise_a, 2'b00);
    check("t2 level_a held", level_a, 2'b01);
    src_a[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t2 fall_a c%0d", k), fall_a, (k == 6) ? 2'b01 : 2'b00);
    end
    repeat (3) tick();

    // ---------------- 3: bounce ----------------
    seen = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 5; j++) begin
        src_a[0] = (j < 3) ? 1'b1 : 1'b0;
        tick();
        seen = seen | level_a | rise_a;
      end
    end
    check("t3 no level/rise during bounce", seen, 2'b00);
    src_a[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t3 rise_a c%0d", k), rise_a, (k == 6) ? 2'b01 : 2'b00);
    end

    // ---------------- 4: hold / repeat ----------------
    for (int k = 1; k <= 60; k++) begin
      tick();
      check($sformatf("t4 hold_a c%0d", k), hold_a, (k == 20) ? 2'b01 : 2'b00);
      check($sformatf("t4 rpt_a c%0d", k), rpt_a,
            (k > 20 && (k - 20) % 8 == 0) ? 2'b01 : 2'b00);
    end
    src_a[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t4 fall_a c%0d", k), fall_a, (k == 6) ? 2'b01 : 2'b00);
      check($sformatf("t4 rpt_a rel c%0d", k), rpt_a, 2'b00);
    end
    seen = '0;
    repeat (20) begin
      tick();
      seen = seen | hold_a | rpt_a;
    end
    check("t4 no pulses after release", seen, 2'b00);

    // ---------------- 5: simultaneous press ----------------
    src_a = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t5 rise_a c%0d", k), rise_a, (k == 6) ? 2'b11 : 2'b00);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      check($sformatf("t5 hold_a c%0d", k), hold_a, (k == 20) ? 2'b01 : 2'b00);
      check($sformatf("t5 fall_a c%0d", k), fall_a, (k == 19) ? 2'b10 : 2'b00);
      check($sformatf("t5 rpt_a c%0d", k), rpt_a, 2'b00);
      if (k == 13) src_a[1] = 1'b0;
    end
    src_a = 2'b00;
    repeat (12) tick();
    check("t5 both released", level_a, 2'b00);

    // ---------------- release on the hold cycle: release wins ----------------
    src_a[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("rw rise_a c%0d", k), rise_a, (k == 6) ? 2'b10 : 2'b00);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      check($sformatf("rw hold_a c%0d", k), hold_a, 2'b00);
      check($sformatf("rw fall_a c%0d", k), fall_a, (k == 20) ? 2'b10 : 2'b00);
      if (k == 14) src_a[1] = 1'b0;
    end

    // ---------------- 6: active-low, no repeat ----------------
    src_b[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t6 fall_b c%0d", k), fall_b, (k == 6) ? 2'b01 : 2'b00);
      check($sformatf("t6 level_b c%0d", k), level_b, (k == 6) ? 2'b10 : 2'b11);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("t6 hold_b c%0d", k), hold_b, (k == 20) ? 2'b01 : 2'b00);
      check($sformatf("t6 rpt_b c%0d", k), rpt_b, 2'b00);
    end
    // press channel 1 then reset mid-hold
    src_b[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t6 fall_b ch1 c%0d", k), fall_b, (k == 6) ? 2'b10 : 2'b00);
    end
    repeat (10) tick();
    #2;
    rst_b_n = 1'b0;
    #1;
    check("t6 async rst level_b", level_b, 2'b11);
    check("t6 async rst pulses", rise_b | fall_b | hold_b | rpt_b, 2'b00);
    tick();
    tick();
    check("t6 rst held level_b", level_b, 2'b11);
    check("t6 rst held pulses", rise_b | fall_b | hold_b | rpt_b, 2'b00);
    rst_b_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t6 post-rst fall_b c%0d", k), fall_b, (k == 6) ? 2'b11 : 2'b00);
      check($sformatf("t6 post-rst rise_b c%0d", k), rise_b, 2'b00);
      check($sformatf("t6 post-rst hold_b c%0d", k), hold_b, 2'b00);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      check($sformatf("t6 post-rst hold2 c%0d", k), hold_b, (k == 20) ? 2'b11 : 2'b00);
      check($sformatf("t6 post-rst rpt_b c%0d", k), rpt_b, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
